fwd_scoreboard: RTL and testbench

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard.sv | 129 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   Tracks the destination register of every in-flight instruction from EXE
//   to WB and resolves operand lookups against it. A lookup that matches a
//   younger stage returns that stage's result bus slice. A lookup whose
//   youngest match is a load that has not yet reached the stage where load
//   data is valid is a load-use hazard. While decode is issuing, that hazard
//   stalls decode and a bubble is inserted into stage 0.
//
// Ports
//   clk          in   clock, all state updates on the rising edge
//   reset        in   synchronous active-high reset
//   issue_valid  in   an instruction leaves decode this cycle
//   issue_rd     in   destination register of the issuing instruction
//   issue_wen    in   issuing instruction writes issue_rd
//   issue_load   in   issuing instruction is a memory load
//   flush        in   squash the issuing instruction
//   stage_data   in   result bus per stage, slice k belongs to stage k
//   rs_valid     in   lookup port p is in use
//   rs           in   source register per lookup port
//   fwd_hit      out  port p is served from the pipeline
//   fwd_data     out  forwarded value per port (zero when not hit)
//   stall        out  load-use hazard, decode holds its instruction
//   stall_count  out  saturating count of stall cycles
module fwd_scoreboard #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int STAGES   = 3,
   parameter int NREAD    = 2,
   parameter int LOAD_LAT = 1,
   parameter int ZERO_REG = 31
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       issue_valid,
   input  logic [ADDR_W-1:0]          issue_rd,
   input  logic                       issue_wen,
   input  logic                       issue_load,
   input  logic                       flush,
   input  logic [STAGES*DATA_W-1:0]   stage_data,
   input  logic [NREAD-1:0]           rs_valid,
   input  logic [NREAD*ADDR_W-1:0]    rs,
   output logic [NREAD-1:0]           fwd_hit,
   output logic [NREAD*DATA_W-1:0]    fwd_data,
   output logic                       stall,
   output logic [15:0]                stall_count
);

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] wen_q,   wen_d;
   logic [STAGES-1:0] load_q,  load_d;
   logic [ADDR_W-1:0] rd_q [STAGES];
   logic [ADDR_W-1:0] rd_d [STAGES];
   logic [15:0]       stall_count_q, stall_count_d;

   logic [NREAD-1:0]  haz;
   logic              capture;

   // Walk stages from oldest to youngest so the youngest candidate
   // overwrites any older match.
   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      haz      = '0;
      for (int p = 0; p < NREAD; p++) begin
         for (int k = STAGES - 1; k >= 0; k--) begin
            if (valid_q[k] && wen_q[k] && rs_valid[p] &&
                (rd_q[k] == rs[p*ADDR_W +: ADDR_W]) &&
                (rs[p*ADDR_W +: ADDR_W] != ZERO_IDX)) begin
               if (load_q[k] && (k < LOAD_LAT)) begin
                  haz[p]                       = 1'b1;
                  fwd_hit[p]                   = 1'b0;
                  fwd_data[p*DATA_W +: DATA_W] = '0;
               end else begin
                  haz[p]                       = 1'b0;
                  fwd_hit[p]                   = 1'b1;
                  fwd_data[p*DATA_W +: DATA_W] = stage_data[k*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   assign stall = issue_valid & (|haz);

   always_comb begin
      // A stalled or flushed issue leaves a bubble in stage 0; older stages
      // advance regardless, which is what lets a load-use stall clear itself.
      capture    = issue_valid && !stall && !flush;
      valid_d[0] = capture;
      rd_d[0]    = capture ? issue_rd : '0;
      wen_d[0]   = capture && issue_wen && (issue_rd != ZERO_IDX);
      load_d[0]  = capture && issue_load;
      for (int k = 1; k < STAGES; k++) begin
         valid_d[k] = valid_q[k-1];
         rd_d[k]    = rd_q[k-1];
         wen_d[k]   = wen_q[k-1];
         load_d[k]  = load_q[k-1];
      end
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != 16'hFFFF)) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q       <= '0;
         wen_q         <= '0;
         load_q        <= '0;
         stall_count_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            rd_q[k] <= '0;
         end
      end else begin
         valid_q       <= valid_d;
         wen_q         <= wen_d;
         load_q        <= load_d;
         stall_count_q <= stall_count_d;
         for (int k = 0; k < STAGES; k++) begin
            rd_q[k] <= rd_d[k];
         end
      end
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard. u_dut uses the default configuration;
// u_sat is a deep load pipeline (8 stages, load data valid only after the
// last stage) so a single load holds a hazard for 8 of every 9 cycles and
// stall_count saturates well within the cycle budget.
module tb_fwd_scoreboard;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   // default instance
   logic          reset;
   logic          issue_valid, issue_wen, issue_load, flush;
   logic [4:0]    issue_rd;
   logic [191:0]  sd;
   logic [1:0]    rsv;
   logic [9:0]    rs;
   logic [1:0]    hit;
   logic [127:0]  fdata;
   logic          stall;
   logic [15:0]   cnt;

   // saturation instance
   logic          reset1;
   logic [127:0]  sd1;
   logic [0:0]    hit1;
   logic [15:0]   fdata1;
   logic          stall1;
   logic [15:0]   cnt1;
   logic [15:0]   exp_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   fwd_scoreboard u_dut (
      .clk         (clk),
      .reset       (reset),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_wen   (issue_wen),
      .issue_load  (issue_load),
      .flush       (flush),
      .stage_data  (sd),
      .rs_valid    (rsv),
      .rs          (rs),
      .fwd_hit     (hit),
      .fwd_data    (fdata),
      .stall       (stall),
      .stall_count (cnt)
   );

   fwd_scoreboard #(
      .DATA_W   (16),
      .STAGES   (8),
      .NREAD    (1),
      .LOAD_LAT (8)
   ) u_sat (
      .clk         (clk),
      .reset       (reset1),
      .issue_valid (1'b1),
      .issue_rd    (5'd4),
      .issue_wen   (1'b1),
      .issue_load  (1'b1),
      .flush       (1'b0),
      .stage_data  (sd1),
      .rs_valid    (1'b1),
      .rs          (5'd4),
      .fwd_hit     (hit1),
      .fwd_data    (fdata1),
      .stall       (stall1),
      .stall_count (cnt1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [4:0] rd, input logic wen, input logic ld);
      issue_valid = 1'b1;
      issue_rd    = rd;
      issue_wen   = wen;
      issue_load  = ld;
   endtask

   initial begin
      reset = 1'b1; reset1 = 1'b1;
      issue_valid = 1'b0; issue_rd = '0; issue_wen = 1'b0; issue_load = 1'b0;
      flush = 1'b0; rsv = '0; rs = '0;
      sd  = {64'h22, 64'h11, 64'h55};
      sd1 = {8{16'h1234}};
      tick(); tick();
      reset = 1'b0;

      // post-reset: nothing tracked
      issue_valid = 1'b0; rsv = 2'b11; rs = {5'd4, 5'd3};
      #1;
      chk("rst_hit",   hit,   2'b00);
      chk("rst_data0", fdata[63:0], 64'h0);
      chk("rst_stall", stall, 1'b0);
      chk("rst_cnt",   cnt,   16'h0);

      // ALU-ALU forwarding through EXE, MEM, WB, then gone
      rsv = 2'b00; issue(5'd3, 1'b1, 1'b0);
      tick();
      issue(5'd0, 1'b0, 1'b0); rsv = 2'b01; rs = {5'd3, 5'd3};
      #1;
      chk("alu_hit_s0",   hit,         2'b01);
      chk("alu_data_s0",  fdata[63:0], 64'h55);
      chk("alu_data_p1",  fdata[127:64], 64'h0);
      chk("alu_stall",    stall,       1'b0);
      tick();
      chk("alu_data_s1",  fdata[63:0], 64'h11);
      tick();
      chk("alu_data_s2",  fdata[63:0], 64'h22);
      tick();
      chk("alu_hit_gone", hit,         2'b00);

      // load-use: one stall cycle, then forwarded from MEM
      rsv = 2'b00; issue(5'd4, 1'b1, 1'b1);
      #1;
      chk("ld_issue_stall", stall, 1'b0);
      tick();
      issue(5'd10, 1'b1, 1'b0); rsv = 2'b10; rs = {5'd4, 5'd0};
      sd = {64'h22, 64'h4444, 64'h55};
      issue_valid = 1'b0;
      #1;
      chk("ld_gate_stall", stall, 1'b0);
      chk("ld_gate_hit",   hit,   2'b00);
      issue_valid = 1'b1;
      #1;
      chk("ld_stall",      stall, 1'b1);
      chk("ld_haz_hit",    hit,   2'b00);
      chk("ld_haz_data",   fdata[127:64], 64'h0);
      tick();
      chk("ld_stall_clr",  stall, 1'b0);
      chk("ld_hit",        hit,   2'b10);
      chk("ld_data",       fdata[127:64], 64'h4444);
      chk("ld_cnt",        cnt,   16'd1);
      tick();
      chk("ld_cnt_hold",   cnt,   16'd1);

      // priority: rd 7 in WB and EXE, rd 8 in MEM
      rsv = 2'b00;
      issue(5'd7, 1'b1, 1'b0); tick();
      issue(5'd8, 1'b1, 1'b0); tick();
      issue(5'd7, 1'b1, 1'b0); tick();
      issue_valid = 1'b0; issue_wen = 1'b0;
      sd = {64'hAA, 64'hCC, 64'hBB};
      rsv = 2'b11; rs = {5'd8, 5'd7};
      #1;
      chk("pri_hit",   hit, 2'b11);
      chk("pri_data0", fdata[63:0],   64'hBB);
      chk("pri_data1", fdata[127:64], 64'hCC);

      // zero register: never tracked, never hazardous
      rsv = 2'b00; tick();
      issue(5'd31, 1'b1, 1'b1); tick();
      issue(5'd0, 1'b0, 1'b0); rsv = 2'b01; rs = {5'd0, 5'd31};
      #1;
      chk("zero_hit",   hit,   2'b00);
      chk("zero_stall", stall, 1'b0);
      chk("zero_data",  fdata[63:0], 64'h0);

      // flush squashes the issuing instruction
      rsv = 2'b00; issue(5'd9, 1'b1, 1'b0); flush = 1'b1; tick();
      flush = 1'b0; issue(5'd0, 1'b0, 1'b0); rsv = 2'b01; rs = {5'd0, 5'd9};
      #1;
      chk("flush_hit", hit, 2'b00);

      // stall with flush: still counted
      rsv = 2'b00; issue(5'd12, 1'b1, 1'b1); tick();
      issue(5'd13, 1'b1, 1'b0); flush = 1'b1; rsv = 2'b01; rs = {5'd0, 5'd12};
      #1;
      chk("sf_stall", stall, 1'b1);
      tick();
      flush = 1'b0; rsv = 2'b01; rs = {5'd0, 5'd13}; issue_valid = 1'b0;
      #1;
      chk("sf_cnt", cnt, 16'd2);
      chk("sf_bubble_hit", hit, 2'b00);

      // reset in the middle of a stall
      rsv = 2'b00; issue(5'd14, 1'b1, 1'b1); tick();
      issue(5'd0, 1'b0, 1'b0); rsv = 2'b01; rs = {5'd0, 5'd14};
      #1;
      chk("mr_stall", stall, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("mr_cnt",   cnt,   16'd0);
      chk("mr_hit",   hit,   2'b00);
      chk("mr_stall_after", stall, 1'b0);

      // saturation on the deep instance: stall on 8 of every 9 edges
      issue_valid = 1'b0; rsv = 2'b00;
      reset1 = 1'b0;
      exp_cnt = 16'd0;
      #1;
      chk("sat_first_stall", stall1, 1'b0);
      for (int i = 0; i < 74000; i++) begin
         if (((i % 9) != 0) && (exp_cnt != 16'hFFFF)) exp_cnt = exp_cnt + 16'd1;
         tick();
         if (i == 8)     chk("sat_cnt_9",     cnt1, 16'd8);
         if (i == 73725) chk("sat_cnt_fffe",  cnt1, 16'hFFFE);
         if (i == 73726) chk("sat_cnt_ffff",  cnt1, 16'hFFFF);
      end
      chk("sat_cnt_model", cnt1, exp_cnt);
      chk("sat_cnt_hold",  cnt1, 16'hFFFF);

      reset1 = 1'b1; reset = 1'b1;
      tick();
      reset1 = 1'b0; reset = 1'b0;
      rsv = 2'b11; rs = {5'd4, 5'd4};
      #1;
      chk("sat_rst_cnt",   cnt1,   16'd0);
      chk("sat_rst_hit",   hit1,   1'b0);
      chk("sat_rst_stall", stall1, 1'b0);
      chk("end_rst_hit",   hit,    2'b00);
      chk("end_rst_cnt",   cnt,    16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
